// File: rtl/my_timer_pio_gen2_pkg.sv
// Shared constants for the my_timer PIO (gen2): register addresses, edge-type
// encodings and the bus word width.
package my_timer_pio_pkg;

    localparam int unsigned BUS_WIDTH = 32;

    typedef logic [BUS_WIDTH-1:0] bus_word_t;
    typedef logic [2:0]           reg_addr_t;

    localparam reg_addr_t ADDR_DATA    = 3'd0;
    localparam reg_addr_t ADDR_DIR     = 3'd1;
    localparam reg_addr_t ADDR_IRQMASK = 3'd2;
    localparam reg_addr_t ADDR_EDGECAP = 3'd3;
    localparam reg_addr_t ADDR_OUTSET  = 3'd4;
    localparam reg_addr_t ADDR_OUTCLR  = 3'd5;

    localparam int unsigned EDGE_RISING  = 0;
    localparam int unsigned EDGE_FALLING = 1;
    localparam int unsigned EDGE_ANY     = 2;

endpackage

// File: rtl/my_timer_pio_gen2_if.sv
// Avalon-MM slave bus bundle for the my_timer PIO (gen2).
interface my_timer_pio_gen2_if;
    import my_timer_pio_pkg::*;

    reg_addr_t address;
    logic      chipselect;
    logic      write_n;
    logic      read_n;
    bus_word_t writedata;
    bus_word_t readdata;

    modport master (
        output address, chipselect, write_n, read_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, read_n, writedata,
        output readdata
    );

endinterface

// File: rtl/my_timer_pio_gen2_sync_edge.sv
// Input synchroniser plus edge detector for the PIO pins.
// With MY_TIMER_PIO_IRQ_EN undefined only the synchroniser is built and the
// edge pulse vector is tied low.
module my_timer_pio_sync_edge
    import my_timer_pio_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned EDGE_TYPE   = EDGE_RISING,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_async,
    output logic [WIDTH-1:0] synced,
    output logic [WIDTH-1:0] edge_pulse
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;

    // Shift raw pad values through the synchroniser chain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_async};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

`ifdef MY_TIMER_PIO_IRQ_EN
    localparam int unsigned ARM_W = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] prev_q;
    logic [ARM_W-1:0] arm_q;
    logic             armed;
    logic [WIDTH-1:0] raw_edge;

    assign armed = (arm_q == ARM_DONE);

    // Delay the synced vector by one cycle and count out the arming window
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= '0;
            arm_q  <= '0;
        end else begin
            prev_q <= synced;
            if (!armed) begin
                arm_q <= arm_q + 1'b1;
            end
        end
    end

    // Compare synced against prev for the configured edge polarity
    always_comb begin
        raw_edge = '0;
        if (EDGE_TYPE == EDGE_RISING) begin
            raw_edge = synced & ~prev_q;
        end else if (EDGE_TYPE == EDGE_FALLING) begin
            raw_edge = ~synced & prev_q;
        end else begin
            raw_edge = synced ^ prev_q;
        end
        // Held-high pins at reset release would otherwise look like edges
        edge_pulse = armed ? raw_edge : '0;
    end
`else
    assign edge_pulse = '0;
`endif

endmodule

// File: rtl/my_timer_pio_gen2.sv
// my_timer PIO gen2: WIDTH-bit bidirectional Avalon-MM GPIO with direction,
// atomic set/clear, edge capture and maskable level interrupt.
// Optional feature macro: MY_TIMER_PIO_IRQ_EN (IRQMASK, EDGECAP, irq).
module my_timer_pio_gen2
    import my_timer_pio_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] OUT_RESET   = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '0,
    parameter int unsigned      EDGE_TYPE   = EDGE_RISING,
    parameter int unsigned      SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    my_timer_pio_gen2_if.slave   bus,
    input  logic [WIDTH-1:0]     in_port,
    output logic [WIDTH-1:0]     out_port,
    output logic [WIDTH-1:0]     oe,
    output logic                 irq
);

    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] synced;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    bus_word_t        rdata_q, rdata_mux;
    logic             unused_wdata;

    assign wr_en = bus.chipselect & ~bus.write_n;
    assign rd_en = bus.chipselect & ~bus.read_n;
    assign wdata = bus.writedata[WIDTH-1:0];
    // Upper writedata bits are don't-care when WIDTH < 32
    assign unused_wdata = ^bus.writedata;

    my_timer_pio_sync_edge #(
        .WIDTH       (WIDTH),
        .EDGE_TYPE   (EDGE_TYPE),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk        (clk),
        .reset      (reset),
        .in_async   (in_port),
        .synced     (synced),
        .edge_pulse (edge_pulse)
    );

    // Next output data and direction from DATA/DIR/OUTSET/OUTCLR writes
    always_comb begin
        out_d = out_q;
        dir_d = dir_q;
        if (wr_en) begin
            case (bus.address)
                ADDR_DATA:   out_d = wdata;
                ADDR_DIR:    dir_d = wdata;
                ADDR_OUTSET: out_d = out_q | wdata;
                ADDR_OUTCLR: out_d = out_q & ~wdata;
                default:     ;
            endcase
        end
    end

    // Output data and direction registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= OUT_RESET;
            dir_q <= DIR_RESET;
        end else begin
            out_q <= out_d;
            dir_q <= dir_d;
        end
    end

    assign out_port = out_q;
    assign oe       = dir_q;

`ifdef MY_TIMER_PIO_IRQ_EN
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic             irq_q;

    // Mask writes and sticky capture; a same-cycle edge beats the W1C
    always_comb begin
        mask_d = mask_q;
        cap_d  = cap_q;
        if (wr_en && bus.address == ADDR_IRQMASK) begin
            mask_d = wdata;
        end
        if (wr_en && bus.address == ADDR_EDGECAP) begin
            cap_d = cap_q & ~wdata;
        end
        cap_d = cap_d | edge_pulse;
    end

    // Mask, capture and registered interrupt
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q <= '0;
            cap_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            cap_q  <= cap_d;
            irq_q  <= |(cap_q & mask_q);
        end
    end

    assign irq = irq_q;
`else
    logic unused_edge;
    assign unused_edge = ^edge_pulse;
    assign irq         = 1'b0;
`endif

    // Read mux: DATA shows the pin view, unused upper bits read zero
    always_comb begin
        rdata_mux = '0;
        case (bus.address)
            ADDR_DATA:    rdata_mux[WIDTH-1:0] = (dir_q & out_q) | (~dir_q & synced);
            ADDR_DIR:     rdata_mux[WIDTH-1:0] = dir_q;
`ifdef MY_TIMER_PIO_IRQ_EN
            ADDR_IRQMASK: rdata_mux[WIDTH-1:0] = mask_q;
            ADDR_EDGECAP: rdata_mux[WIDTH-1:0] = cap_q;
`endif
            default:      ;
        endcase
    end

    // Registered read data, held between reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (rd_en) begin
            rdata_q <= rdata_mux;
        end
    end

    assign bus.readdata = rdata_q;

endmodule

// File: tb/tb_my_timer_pio_gen2.sv
// Self-checking bench for my_timer_pio_gen2: directed scenarios followed by
// random bus traffic, pin toggling and resets, all compared every cycle
// against a behavioural model of the register file and delayed pin view.
module tb_my_timer_pio_gen2;
    import my_timer_pio_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned SS = 2;
    localparam int unsigned ET = EDGE_RISING;
    localparam logic [7:0]  OR = 8'hA5;
    localparam logic [7:0]  DR = 8'hFF;
`ifdef MY_TIMER_PIO_IRQ_EN
    localparam bit IrqOn = 1'b1;
`else
    localparam bit IrqOn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_port;
    logic [7:0] out_port;
    logic [7:0] oe;
    logic       irq;
    logic [7:0] cur_in;

    my_timer_pio_gen2_if bus ();

    my_timer_pio_gen2 #(
        .WIDTH       (W),
        .OUT_RESET   (OR),
        .DIR_RESET   (DR),
        .EDGE_TYPE   (ET),
        .SYNC_STAGES (SS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .in_port  (in_port),
        .out_port (out_port),
        .oe       (oe),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: registers plus the history of sampled pin values
    logic [7:0]  m_out, m_dir, m_mask, m_cap;
    logic        m_irq;
    logic [31:0] m_rdata;
    logic [7:0]  hist [0:SS];
    int          m_n;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_out   = OR;
        m_dir   = DR;
        m_mask  = '0;
        m_cap   = '0;
        m_irq   = 1'b0;
        m_rdata = '0;
        for (int i = 0; i <= SS; i++) hist[i] = '0;
        m_n = 0;
    endtask

    // One clock edge of the specified behaviour
    task automatic model_step(input logic cs, input logic wr_n, input logic rd_n,
                              input logic [2:0] a, input logic [31:0] wd,
                              input logic [7:0] pin);
        logic [7:0] synced, prev, edges, w, clr, view;
        synced = hist[SS-1];
        prev   = hist[SS];
        edges  = '0;
        if (m_n >= SS + 1) begin
            if (ET == EDGE_RISING)       edges = synced & ~prev;
            else if (ET == EDGE_FALLING) edges = ~synced & prev;
            else                         edges = synced ^ prev;
        end
        case (a)
            3'd0:    view = (m_out & m_dir) | (~m_dir & synced);
            3'd1:    view = m_dir;
            3'd2:    view = IrqOn ? m_mask : 8'h00;
            3'd3:    view = IrqOn ? m_cap : 8'h00;
            default: view = 8'h00;
        endcase
        if (cs && !rd_n) m_rdata = {24'h0, view};
        m_irq = IrqOn && ((m_cap & m_mask) != 8'h00);
        w   = wd[7:0];
        clr = '0;
        if (cs && !wr_n) begin
            case (a)
                3'd0: m_out = w;
                3'd1: m_dir = w;
                3'd2: m_mask = w;
                3'd3: clr = w;
                3'd4: m_out = m_out | w;
                3'd5: m_out = m_out & ~w;
                default: ;
            endcase
        end
        m_cap = (m_cap & ~clr) | edges;
        for (int i = SS; i >= 1; i--) hist[i] = hist[i-1];
        hist[0] = pin;
        if (m_n < SS + 1) m_n++;
    endtask

    task automatic compare_all();
        check("out_port", {24'h0, out_port}, {24'h0, m_out});
        check("oe", {24'h0, oe}, {24'h0, m_dir});
        check("irq", {31'h0, irq}, {31'h0, m_irq});
        check("readdata", bus.readdata, m_rdata);
    endtask

    task automatic tick(input logic cs, input logic wr_n, input logic rd_n,
                        input logic [2:0] a, input logic [31:0] wd);
        bus.chipselect = cs;
        bus.write_n    = wr_n;
        bus.read_n     = rd_n;
        bus.address    = a;
        bus.writedata  = wd;
        in_port        = cur_in;
        @(posedge clk);
        model_step(cs, wr_n, rd_n, a, wd, cur_in);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 1'b1, 3'd0, 32'h0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        tick(1'b1, 1'b0, 1'b1, a, d);
    endtask

    task automatic rd(input logic [2:0] a);
        tick(1'b1, 1'b1, 1'b0, a, 32'h0);
    endtask

    // Asynchronous reset mid-cycle, optionally with a read pending
    task automatic do_reset(input bit with_read);
        bus.chipselect = with_read;
        bus.read_n     = ~with_read;
        bus.write_n    = 1'b1;
        bus.address    = 3'd0;
        in_port        = cur_in;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        reset = 1'b0;
        bus.chipselect = 1'b0;
        bus.read_n     = 1'b1;
    endtask

    initial begin
        reset          = 1'b1;
        cur_in         = 8'h00;
        in_port        = 8'h00;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.read_n     = 1'b1;
        bus.address    = 3'd0;
        bus.writedata  = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_out", {24'h0, out_port}, 32'hA5);
        check("rst_oe", {24'h0, oe}, 32'hFF);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_rdata", bus.readdata, 32'h0);

        rd(3'd0);
        check("rd_data_reset", bus.readdata, 32'h0000_00A5);

        wr(3'd0, 32'h00);
        wr(3'd4, 32'h0F);
        check("outset", {24'h0, out_port}, 32'h0F);
        wr(3'd5, 32'h81);
        check("outclr", {24'h0, out_port}, 32'h0E);
        rd(3'd4);
        check("rd_outset", bus.readdata, 32'h0);
        rd(3'd0);
        rd(3'd5);
        check("rd_outclr", bus.readdata, 32'h0);

        wr(3'd1, 32'h0F);
        wr(3'd0, 32'h3C);
        cur_in = 8'hA0;
        idle(3);
        rd(3'd0);
        check("pin_view", bus.readdata, 32'hAC);

        wr(3'd3, 32'hFF);
        wr(3'd2, 32'h02);
        idle(2);
        cur_in = 8'hA2;
        idle(4);
        rd(3'd3);
        check("edgecap", bus.readdata, IrqOn ? 32'h02 : 32'h00);
        idle(1);
        check("irq_set", {31'h0, irq}, {31'h0, IrqOn});
        wr(3'd3, 32'h02);
        idle(1);
        check("irq_clr", {31'h0, irq}, 32'h0);

        cur_in = 8'hA0;
        idle(4);
        wr(3'd3, 32'hFF);
        cur_in = 8'hA2;
        idle(2);
        wr(3'd3, 32'h02);
        rd(3'd3);
        check("edge_beats_w1c", bus.readdata, IrqOn ? 32'h02 : 32'h00);

        if (!IrqOn) begin
            wr(3'd2, 32'hFF);
            for (int i = 0; i < 6; i++) begin
                cur_in = ~cur_in;
                idle(1);
            end
            rd(3'd2);
            check("rd_mask_off", bus.readdata, 32'h0);
            rd(3'd3);
            check("rd_cap_off", bus.readdata, 32'h0);
            check("irq_off", {31'h0, irq}, 32'h0);
        end

        cur_in = 8'hFF;
        do_reset(1'b1);
        check("rst_rd_pending", bus.readdata, 32'h0);
        idle(6);
        rd(3'd3);
        check("held_high_cap", bus.readdata, 32'h0);
        check("held_high_irq", {31'h0, irq}, 32'h0);

        wr(3'd2, 32'hFF);
        for (int it = 0; it < 800; it++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if ($urandom_range(0, 99) < 30) cur_in = 8'($urandom);
            if (r < 2) begin
                do_reset(1'($urandom));
            end else if (r < 35) begin
                idle(1);
            end else if (r < 65) begin
                rd(3'($urandom));
            end else begin
                wr(3'($urandom), $urandom);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
